// File: rtl/gate_truth_checker.sv
// Checks observed AND/NOR/AND/NAND outputs against stimulus bits over a run of NUM_SAMPLES valid samples.
// Latency: counters update one cycle after acceptance; DONE/pass are registered on the edge of the last sample.
// Backpressure: none; every in_valid cycle in RUN is accepted. Optional coverage via macro GATE_CHK_COV_EN.
module gate_truth_checker #(
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 8,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             in_d,
  input  logic             in_e,
  input  logic             in_g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic [5:0]       first_err
`ifdef GATE_CHK_COV_EN
  ,
  output logic [3:0]       cov
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [5:0]       first_err_q, first_err_d;
  logic             mismatch;
  logic             cov_full;
`ifdef GATE_CHK_COV_EN
  logic [3:0]       cov_q, cov_d;
`endif

  // Compare each observed gate output against the value implied by a and b.
  always_comb begin
    mismatch = (in_c != (in_a & in_b))    ||
               (in_d != ~(in_a | in_b))   ||
               (in_e != (in_a & in_b))    ||
               (in_g != ~(in_a & in_b));
  end

  // Next-state, counter and verdict logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_err_d  = first_err_q;
`ifdef GATE_CHK_COV_EN
    cov_d        = cov_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          sample_cnt_d = '0;
          err_cnt_d    = '0;
          first_err_d  = '0;
`ifdef GATE_CHK_COV_EN
          cov_d        = '0;
`endif
        end
      end
      RUN: begin
        if (in_valid) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (mismatch) begin
            // err_cnt still zero means this is the first mismatch of the run.
            if (err_cnt_q == '0) first_err_d = {in_a, in_b, in_c, in_d, in_e, in_g};
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
          end
`ifdef GATE_CHK_COV_EN
          cov_d[{in_a, in_b}] = 1'b1;
`endif
          if (sample_cnt_d == CNT_W'(NUM_SAMPLES)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef GATE_CHK_COV_EN
    cov_full = (cov_d == 4'b1111);
`else
    cov_full = 1'b1;
`endif
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_cnt_d == '0) && cov_full;
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
`ifdef GATE_CHK_COV_EN
      cov_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_err_q  <= first_err_d;
`ifdef GATE_CHK_COV_EN
      cov_q        <= cov_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign first_err  = first_err_q;
`ifdef GATE_CHK_COV_EN
  assign cov        = cov_q;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: default instance plus an ERR_W=2, NUM_SAMPLES=6 instance.
// Inputs driven 1 time unit after the rising edge; outputs sampled the same way.
// Coverage checks appear when GATE_CHK_COV_EN is defined.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic in_valid = 1'b0;
  logic in_a = 1'b0, in_b = 1'b0, in_c = 1'b0, in_d = 1'b0, in_e = 1'b0, in_g = 1'b0;

  logic       busy, done, pass;
  logic [7:0] sample_cnt, err_cnt;
  logic [5:0] first_err;
  logic       busy2, done2, pass2;
  logic [7:0] sample_cnt2;
  logic [1:0] err_cnt2;
  logic [5:0] first_err2;
`ifdef GATE_CHK_COV_EN
  logic [3:0] cov, cov2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_truth_checker #(.NUM_SAMPLES(4), .CNT_W(8), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e), .in_g(in_g),
    .busy(busy), .done(done), .pass(pass), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .first_err(first_err)
`ifdef GATE_CHK_COV_EN
    , .cov(cov)
`endif
  );

  gate_truth_checker #(.NUM_SAMPLES(6), .CNT_W(8), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e), .in_g(in_g),
    .busy(busy2), .done(done2), .pass(pass2), .sample_cnt(sample_cnt2),
    .err_cnt(err_cnt2), .first_err(first_err2)
`ifdef GATE_CHK_COV_EN
    , .cov(cov2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample with explicit observed bits.
  task automatic send(input logic a, input logic b, input logic c, input logic d,
                      input logic e, input logic g);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_d = d; in_e = e; in_g = g;
    tick();
    in_valid = 1'b0;
  endtask

  // One valid sample whose observed bits are the correct gate outputs.
  task automatic send_ok(input logic a, input logic b);
    send(a, b, a & b, ~(a | b), a & b, ~(a & b));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done, pass, sample_cnt, err_cnt, first_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b pass=%b cnt=%0d err=%0d ferr=%b want all 0",
               busy, done, pass, sample_cnt, err_cnt, first_err);
    end
    tick();
    rst_n = 1'b1;
    #2;
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_hold got busy=%b done=%b pass=%b want 000", busy, done, pass);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 00", busy, done);
    end
  endtask

  task automatic test_all_pass();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_cnt !== 8'd0) begin
      errors++;
      $display("FAIL run_entry got busy=%b done=%b cnt=%0d want 1 0 0", busy, done, sample_cnt);
    end
    send_ok(1'b0, 1'b0);
    checks++;
    if (sample_cnt !== 8'd1) begin
      errors++;
      $display("FAIL cnt_after_one got %0d want 1", sample_cnt);
    end
    send_ok(1'b0, 1'b1);
    send_ok(1'b1, 1'b0);
    send_ok(1'b1, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_cnt !== 8'd0 || sample_cnt !== 8'd4) begin
      errors++;
      $display("FAIL all_pass got done=%b busy=%b pass=%b err=%0d cnt=%0d want 1 0 1 0 4",
               done, busy, pass, err_cnt, sample_cnt);
    end
`ifdef GATE_CHK_COV_EN
    checks++;
    if (cov !== 4'b1111) begin
      errors++;
      $display("FAIL all_pass_cov got %b want 1111", cov);
    end
`endif
    // A sample in DONE must be ignored.
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sample_cnt !== 8'd4 || err_cnt !== 8'd0 || done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL done_hold got cnt=%0d err=%0d done=%b pass=%b want 4 0 1 1",
               sample_cnt, err_cnt, done, pass);
    end
  endtask

  task automatic test_single_err();
    pulse_start();
    checks++;
    if (sample_cnt !== 8'd0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear got cnt=%0d done=%b pass=%b want 0 0 0", sample_cnt, done, pass);
    end
    send_ok(1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);   // second mismatch must not overwrite first_err
    send_ok(1'b1, 1'b1);
    checks++;
    if (err_cnt !== 8'd2 || pass !== 1'b0 || done !== 1'b1 || first_err !== 6'b101001) begin
      errors++;
      $display("FAIL single_err got err=%0d pass=%b done=%b ferr=%b want 2 0 1 101001",
               err_cnt, pass, done, first_err);
    end
    pulse_start();
    send_ok(1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_ok(1'b0, 1'b1);
    send_ok(1'b1, 1'b1);
    checks++;
    if (err_cnt !== 8'd1 || pass !== 1'b0 || first_err !== 6'b101001) begin
      errors++;
      $display("FAIL one_err got err=%0d pass=%b ferr=%b want 1 0 101001", err_cnt, pass, first_err);
    end
  endtask

  task automatic test_saturate();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 3) begin
        checks++;
        if (err_cnt2 !== 2'd3) begin
          errors++;
          $display("FAIL sat_hold got %0d want 3", err_cnt2);
        end
      end
    end
    checks++;
    if (err_cnt2 !== 2'd3 || pass2 !== 1'b0 || done2 !== 1'b1 || sample_cnt2 !== 8'd6 ||
        first_err2 !== 6'b001010) begin
      errors++;
      $display("FAIL saturate got err=%0d pass=%b done=%b cnt=%0d ferr=%b want 3 0 1 6 001010",
               err_cnt2, pass2, done2, sample_cnt2, first_err2);
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    send_ok(1'b1, 1'b1);
    tick();
    pulse_start();
    send_ok(1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (sample_cnt !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL gaps_mid got cnt=%0d busy=%b done=%b want 2 1 0", sample_cnt, busy, done);
    end
    start = 1'b1;
    send_ok(1'b1, 1'b0);
    start = 1'b0;
    send_ok(1'b0, 1'b0);
    checks++;
    if (sample_cnt !== 8'd4 || done !== 1'b1 || pass !== 1'b1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL gaps_end got cnt=%0d done=%b pass=%b err=%0d want 4 1 1 0",
               sample_cnt, done, pass, err_cnt);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_ok(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, sample_cnt, err_cnt, first_err} !== 23'd0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b pass=%b cnt=%0d err=%0d ferr=%b want all 0",
               busy, done, pass, sample_cnt, err_cnt, first_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_ok(1'b0, 1'b0);
    send_ok(1'b0, 1'b1);
    send_ok(1'b1, 1'b0);
    send_ok(1'b1, 1'b1);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 8'd0 || first_err !== 6'd0 || sample_cnt !== 8'd4) begin
      errors++;
      $display("FAIL clean_run got done=%b pass=%b err=%0d ferr=%b cnt=%0d want 1 1 0 0 4",
               done, pass, err_cnt, first_err, sample_cnt);
    end
  endtask

`ifdef GATE_CHK_COV_EN
  task automatic test_cov();
    pulse_start();
    for (int i = 0; i < 4; i++) send_ok(1'b1, 1'b1);
    checks++;
    if (err_cnt !== 8'd0 || cov !== 4'b1000 || pass !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL cov_partial got err=%0d cov=%b pass=%b done=%b want 0 1000 0 1",
               err_cnt, cov, pass, done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_pass();
    test_single_err();
    test_saturate();
    test_gaps();
    test_mid_reset();
`ifdef GATE_CHK_COV_EN
    test_cov();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
